alu_unit: RTL and testbench

Execution unit at the receiving end of the reservation-station issue port. Accepts at most one ready operation per cycle, computes the integer/branch result, and queues it in a small FIFO. Drives the result onto the ALU CDB slot when the CDB arbiter grants it. Asserts `busy` back to the station so issue is throttled before the queue overflows.

---
 rtl/alu_unit.sv | 207 ++++++++++++++++++++
 tb/tb_alu_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// alu_unit: integer/branch execution unit behind a reservation-station issue port.
//
// Computes one operation per cycle combinationally and pushes the result into a
// small in-order FIFO. The FIFO head is presented to the ALU CDB slot and popped
// when the arbiter grants it.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   rdy_in                  global enable; low freezes all state
//   op_enum_from_rs         operation code (0 = no issue), encoding in op_e below
//   V1_from_rs, V2_from_rs  source operands
//   imm_from_rs             immediate
//   inst_pos_from_rs        instruction PC
//   rob_id_from_rs          destination ROB tag
//   busy_to_rs              station must not issue next cycle
//   grant_from_cdb          arbiter accepts the current head this cycle
//   enable_to_cdb           head valid
//   rob_id_to_cdb           head tag
//   result_to_cdb           head rd value
//   jump_to_cdb             head control transfer taken
//   target_to_cdb           head next PC (branch/jump ops, else 0)
//   rollback_flag_from_rob  flush: empties the FIFO next cycle
module alu_unit #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned ROB_W       = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic [4:0]       op_enum_from_rs,
    input  logic [31:0]      V1_from_rs,
    input  logic [31:0]      V2_from_rs,
    input  logic [31:0]      imm_from_rs,
    input  logic [31:0]      inst_pos_from_rs,
    input  logic [ROB_W-1:0] rob_id_from_rs,
    output logic             busy_to_rs,
    input  logic             grant_from_cdb,
    output logic             enable_to_cdb,
    output logic [ROB_W-1:0] rob_id_to_cdb,
    output logic [31:0]      result_to_cdb,
    output logic             jump_to_cdb,
    output logic [31:0]      target_to_cdb,
    input  logic             rollback_flag_from_rob
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [4:0] {
        OpReset = 5'd0,
        OpAdd   = 5'd1,  OpAddi  = 5'd2,  OpSub   = 5'd3,
        OpAnd   = 5'd4,  OpAndi  = 5'd5,  OpOr    = 5'd6,  OpOri   = 5'd7,
        OpXor   = 5'd8,  OpXori  = 5'd9,
        OpSll   = 5'd10, OpSlli  = 5'd11, OpSrl   = 5'd12, OpSrli  = 5'd13,
        OpSra   = 5'd14, OpSrai  = 5'd15,
        OpSlt   = 5'd16, OpSlti  = 5'd17, OpSltu  = 5'd18, OpSltiu = 5'd19,
        OpLui   = 5'd20, OpAuipc = 5'd21, OpJal   = 5'd22, OpJalr  = 5'd23,
        OpBeq   = 5'd24, OpBne   = 5'd25, OpBlt   = 5'd26, OpBge   = 5'd27,
        OpBltu  = 5'd28, OpBgeu  = 5'd29
    } op_e;

    typedef struct packed {
        logic [ROB_W-1:0] rob_id;
        logic [31:0]      result;
        logic             jump;
        logic [31:0]      target;
    } entry_t;

    op_e         op;
    logic [31:0] v1, v2, imm, pc;
    logic [31:0] pc_plus4, pc_plus_imm;
    logic [31:0] alu_res, alu_tgt;
    logic        alu_jmp;
    logic        br_cond;

    assign op          = op_e'(op_enum_from_rs);
    assign v1          = V1_from_rs;
    assign v2          = V2_from_rs;
    assign imm         = imm_from_rs;
    assign pc          = inst_pos_from_rs;
    assign pc_plus4    = pc + 32'd4;
    assign pc_plus_imm = pc + imm;

    always_comb begin
        br_cond = 1'b0;
        unique case (op)
            OpBeq:   br_cond = (v1 == v2);
            OpBne:   br_cond = (v1 != v2);
            OpBlt:   br_cond = ($signed(v1) < $signed(v2));
            OpBge:   br_cond = ($signed(v1) >= $signed(v2));
            OpBltu:  br_cond = (v1 < v2);
            OpBgeu:  br_cond = (v1 >= v2);
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = 32'd0;
        alu_jmp = 1'b0;
        alu_tgt = 32'd0;
        case (op)
            OpAdd:   alu_res = v1 + v2;
            OpAddi:  alu_res = v1 + imm;
            OpSub:   alu_res = v1 - v2;
            OpAnd:   alu_res = v1 & v2;
            OpAndi:  alu_res = v1 & imm;
            OpOr:    alu_res = v1 | v2;
            OpOri:   alu_res = v1 | imm;
            OpXor:   alu_res = v1 ^ v2;
            OpXori:  alu_res = v1 ^ imm;
            OpSll:   alu_res = v1 << v2[4:0];
            OpSlli:  alu_res = v1 << imm[4:0];
            OpSrl:   alu_res = v1 >> v2[4:0];
            OpSrli:  alu_res = v1 >> imm[4:0];
            OpSra:   alu_res = $unsigned($signed(v1) >>> v2[4:0]);
            OpSrai:  alu_res = $unsigned($signed(v1) >>> imm[4:0]);
            OpSlt:   alu_res = {31'd0, $signed(v1) < $signed(v2)};
            OpSlti:  alu_res = {31'd0, $signed(v1) < $signed(imm)};
            OpSltu:  alu_res = {31'd0, v1 < v2};
            OpSltiu: alu_res = {31'd0, v1 < imm};
            OpLui:   alu_res = imm;
            OpAuipc: alu_res = pc_plus_imm;
            OpJal: begin
                alu_res = pc_plus4;
                alu_jmp = 1'b1;
                alu_tgt = pc_plus_imm;
            end
            OpJalr: begin
                alu_res = pc_plus4;
                alu_jmp = 1'b1;
                alu_tgt = (v1 + imm) & ~32'd1;
            end
            OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu: begin
                alu_jmp = br_cond;
                alu_tgt = br_cond ? pc_plus_imm : pc_plus4;
            end
            default: ;
        endcase
    end

    // Result FIFO
    entry_t          mem_q [QUEUE_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            issue_valid, full, nonempty, push, pop;
    entry_t          new_entry, head;

    assign issue_valid = (op != OpReset);
    assign full        = (count_q == CntW'(QUEUE_DEPTH));
    assign nonempty    = (count_q != '0);
    // An issue while full is a protocol violation and is simply dropped.
    assign push        = rdy_in && !rollback_flag_from_rob && issue_valid && !full;
    assign pop         = rdy_in && !rollback_flag_from_rob && nonempty && grant_from_cdb;

    assign new_entry.rob_id = rob_id_from_rs;
    assign new_entry.result = alu_res;
    assign new_entry.jump   = alu_jmp;
    assign new_entry.target = alu_tgt;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (rollback_flag_from_rob) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_d = count_q + CntW'(1);
            else if (pop && !push) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed below count_q.
    always_ff @(posedge clk_in) begin
        if (!rst_in && push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign enable_to_cdb = nonempty;
    // Gate data with valid so an empty queue (reset/rollback) shows all zeros.
    assign rob_id_to_cdb = nonempty ? head.rob_id : '0;
    assign result_to_cdb = nonempty ? head.result : 32'd0;
    assign jump_to_cdb   = nonempty ? head.jump   : 1'b0;
    assign target_to_cdb = nonempty ? head.target : 32'd0;

    // Leaves room for the issue already in flight when busy is first seen.
    assign busy_to_rs = (count_q >= CntW'(QUEUE_DEPTH - 1));

endmodule

// File: tb/tb_alu_unit.sv
module tb_alu_unit;

    localparam logic [4:0] OpReset = 5'd0,  OpAdd  = 5'd1,  OpAddi = 5'd2,  OpSub  = 5'd3;
    localparam logic [4:0] OpAndi  = 5'd5,  OpXor  = 5'd8,  OpSll  = 5'd10, OpSrli = 5'd13;
    localparam logic [4:0] OpSra   = 5'd14, OpSlt  = 5'd16, OpSltu = 5'd18, OpLui  = 5'd20;
    localparam logic [4:0] OpAuipc = 5'd21, OpJal  = 5'd22, OpJalr = 5'd23, OpBeq  = 5'd24;
    localparam logic [4:0] OpBne   = 5'd25, OpBlt  = 5'd26, OpBltu = 5'd28, OpBgeu = 5'd29;
    localparam int NumVec = 18;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, grant, rollback;
    logic [4:0]  op;
    logic [31:0] v1, v2, imm, pc;
    logic [3:0]  rob;
    logic        busy, en, jmp_o;
    logic [3:0]  rob_o;
    logic [31:0] res_o, tgt_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] v1, v2, imm, pc;
        logic [3:0]  rob;
        logic [31:0] res;
        logic        jmp;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs [NumVec];

    alu_unit #(.QUEUE_DEPTH(4), .ROB_W(4)) dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .rdy_in                 (rdy_in),
        .op_enum_from_rs        (op),
        .V1_from_rs             (v1),
        .V2_from_rs             (v2),
        .imm_from_rs            (imm),
        .inst_pos_from_rs       (pc),
        .rob_id_from_rs         (rob),
        .busy_to_rs             (busy),
        .grant_from_cdb         (grant),
        .enable_to_cdb          (en),
        .rob_id_to_cdb          (rob_o),
        .result_to_cdb          (res_o),
        .jump_to_cdb            (jmp_o),
        .target_to_cdb          (tgt_o),
        .rollback_flag_from_rob (rollback)
    );

    always #5 clk_in = ~clk_in;

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] i, input logic [31:0] p, input logic [3:0] t);
        op = o; v1 = a; v2 = b; imm = i; pc = p; rob = t;
    endtask

    task automatic idle();
        op = OpReset; v1 = '0; v2 = '0; imm = '0; pc = '0; rob = '0;
    endtask

    // ADDI with V1=100 tags entries with a recognisable result 100+k.
    task automatic issue_k(input logic [3:0] t, input logic [31:0] k);
        issue(OpAddi, 32'd100, 32'd0, k, 32'd0, t);
    endtask

    task automatic chk_head(input string name, input logic [3:0] t, input logic [31:0] r);
        chk({name, " en"}, {31'd0, en}, 32'd1);
        chk({name, " rob"}, {28'd0, rob_o}, {28'd0, t});
        chk({name, " res"}, res_o, r);
    endtask

    initial begin
        vecs[0]  = '{OpAdd,   32'd5,         32'd7,         32'd0,         32'h0,   4'd3,  32'd12,        1'b0, 32'h0};
        vecs[1]  = '{OpSub,   32'd3,         32'd5,         32'd0,         32'h0,   4'd1,  32'hFFFFFFFE,  1'b0, 32'h0};
        vecs[2]  = '{OpSra,   32'h80000000,  32'h24,        32'd0,         32'h0,   4'd2,  32'hF8000000,  1'b0, 32'h0};
        vecs[3]  = '{OpSltu,  32'hFFFFFFFF,  32'd1,         32'd0,         32'h0,   4'd4,  32'd0,         1'b0, 32'h0};
        vecs[4]  = '{OpSlt,   32'hFFFFFFFF,  32'd1,         32'd0,         32'h0,   4'd5,  32'd1,         1'b0, 32'h0};
        vecs[5]  = '{OpAndi,  32'hF0F0,      32'hFFFF,      32'hFF,        32'h0,   4'd6,  32'hF0,        1'b0, 32'h0};
        vecs[6]  = '{OpXor,   32'hFF00,      32'h0FF0,      32'd0,         32'h0,   4'd7,  32'hF0F0,      1'b0, 32'h0};
        vecs[7]  = '{OpSrli,  32'h80000000,  32'd0,         32'd31,        32'h0,   4'd8,  32'd1,         1'b0, 32'h0};
        vecs[8]  = '{OpSll,   32'd1,         32'h21,        32'd0,         32'h0,   4'd9,  32'd2,         1'b0, 32'h0};
        vecs[9]  = '{OpLui,   32'd0,         32'd0,         32'h12345000,  32'h0,   4'd10, 32'h12345000,  1'b0, 32'h0};
        vecs[10] = '{OpAuipc, 32'd0,         32'd0,         32'h1000,      32'h100, 4'd11, 32'h1100,      1'b0, 32'h0};
        vecs[11] = '{OpJal,   32'd0,         32'd0,         32'h40,        32'h100, 4'd12, 32'h104,       1'b1, 32'h140};
        vecs[12] = '{OpJalr,  32'h203,       32'd0,         32'd0,         32'h40,  4'd13, 32'h44,        1'b1, 32'h202};
        vecs[13] = '{OpBne,   32'd1,         32'd2,         32'h20,        32'h100, 4'd14, 32'd0,         1'b1, 32'h120};
        vecs[14] = '{OpBeq,   32'd1,         32'd2,         32'h20,        32'h100, 4'd15, 32'd0,         1'b0, 32'h104};
        vecs[15] = '{OpBlt,   32'hFFFFFFFF,  32'd1,         32'hFFFFFFF0,  32'h200, 4'd0,  32'd0,         1'b1, 32'h1F0};
        vecs[16] = '{OpBgeu,  32'hFFFFFFFF,  32'd1,         32'd8,         32'h80,  4'd1,  32'd0,         1'b1, 32'h88};
        vecs[17] = '{OpBltu,  32'hFFFFFFFF,  32'd1,         32'd8,         32'h80,  4'd2,  32'd0,         1'b0, 32'h84};

        rst_in = 1'b1; rdy_in = 1'b1; grant = 1'b0; rollback = 1'b0;
        idle();
        tick(); tick();
        rst_in = 1'b0;
        chk("reset en", {31'd0, en}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset rob", {28'd0, rob_o}, 32'd0);
        chk("reset res", res_o, 32'd0);
        chk("reset jump", {31'd0, jmp_o}, 32'd0);
        chk("reset target", tgt_o, 32'd0);

        // Single-op vectors: issue, check head next cycle, grant, check empty.
        for (int i = 0; i < NumVec; i++) begin
            issue(vecs[i].op, vecs[i].v1, vecs[i].v2, vecs[i].imm, vecs[i].pc, vecs[i].rob);
            tick();
            idle();
            chk($sformatf("vec%0d en", i), {31'd0, en}, 32'd1);
            chk($sformatf("vec%0d rob", i), {28'd0, rob_o}, {28'd0, vecs[i].rob});
            chk($sformatf("vec%0d res", i), res_o, vecs[i].res);
            chk($sformatf("vec%0d jump", i), {31'd0, jmp_o}, {31'd0, vecs[i].jmp});
            chk($sformatf("vec%0d target", i), tgt_o, vecs[i].tgt);
            grant = 1'b1;
            tick();
            grant = 1'b0;
            chk($sformatf("vec%0d drained", i), {31'd0, en}, 32'd0);
        end

        // Busy threshold: three pushes with grant low, then in-order drain.
        for (int k = 0; k < 3; k++) begin
            issue_k(4'(10 + k), 32'(k));
            tick();
            chk($sformatf("busy after push%0d", k + 1), {31'd0, busy}, (k == 2) ? 32'd1 : 32'd0);
        end
        idle();
        tick();
        chk("busy holds", {31'd0, busy}, 32'd1);
        chk_head("busy q0", 4'd10, 32'd100);
        grant = 1'b1;
        tick();
        chk("busy after pop", {31'd0, busy}, 32'd0);
        chk_head("busy q1", 4'd11, 32'd101);
        tick();
        chk_head("busy q2", 4'd12, 32'd102);
        tick();
        chk("busy drained", {31'd0, en}, 32'd0);
        grant = 1'b0;

        // Overfill: fourth push fills the queue, fifth is dropped.
        for (int k = 0; k < 4; k++) begin
            issue_k(4'(4 + k), 32'(k));
            tick();
        end
        chk("full busy", {31'd0, busy}, 32'd1);
        issue_k(4'd9, 32'd9);
        tick();
        idle();
        grant = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_head($sformatf("full q%0d", k), 4'(4 + k), 32'(100 + k));
            tick();
        end
        chk("full dropped", {31'd0, en}, 32'd0);
        grant = 1'b0;

        // Simultaneous push and pop with two entries queued.
        issue_k(4'd1, 32'd1); tick();
        issue_k(4'd2, 32'd2); tick();
        chk("pp busy before", {31'd0, busy}, 32'd0);
        issue_k(4'd3, 32'd3);
        grant = 1'b1;
        tick();
        idle();
        chk("pp busy after", {31'd0, busy}, 32'd0);
        chk_head("pp q2", 4'd2, 32'd102);
        tick();
        chk_head("pp q3", 4'd3, 32'd103);
        tick();
        chk("pp drained", {31'd0, en}, 32'd0);
        grant = 1'b0;

        // Pointer wrap: one entry in flight, push+pop for ten cycles.
        issue_k(4'd0, 32'd0); tick();
        grant = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            issue_k(4'(k), 32'(k));
            tick();
            chk_head($sformatf("wrap%0d", k), 4'(k), 32'(100 + k));
            chk($sformatf("wrap%0d busy", k), {31'd0, busy}, 32'd0);
        end
        idle();
        tick();
        chk("wrap drained", {31'd0, en}, 32'd0);
        grant = 1'b0;

        // rdy low freezes: grant and issue ignored, head held.
        issue_k(4'd1, 32'd1); tick();
        rdy_in = 1'b0;
        grant = 1'b1;
        issue_k(4'd2, 32'd2);
        tick();
        idle();
        chk_head("frozen", 4'd1, 32'd101);
        rdy_in = 1'b1;
        tick();
        chk("frozen issue dropped", {31'd0, en}, 32'd0);
        grant = 1'b0;

        // Rollback with two queued entries plus a same-cycle issue and grant.
        issue_k(4'd1, 32'd1); tick();
        issue_k(4'd2, 32'd2); tick();
        chk("pre-rollback en", {31'd0, en}, 32'd1);
        issue_k(4'd3, 32'd3);
        grant = 1'b1;
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        grant = 1'b0;
        idle();
        chk("rollback en", {31'd0, en}, 32'd0);
        chk("rollback busy", {31'd0, busy}, 32'd0);
        chk("rollback rob", {28'd0, rob_o}, 32'd0);
        chk("rollback res", res_o, 32'd0);
        issue(OpAdd, 32'd5, 32'd7, 32'd0, 32'd0, 4'd7);
        tick();
        idle();
        chk_head("post-rollback", 4'd7, 32'd12);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        chk("post-rollback alone", {31'd0, en}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
